// File: rtl/timer_scheduler_if.sv
// Command / event bus of the four-channel timer scheduler.
// master = the side issuing commands and consuming events; slave = the scheduler.
interface timer_scheduler_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [1:0]       cmd_ch;
  logic [CNT_W-1:0] cmd_load;
  logic             cmd_periodic;
  logic             tick;
  logic [3:0]       running;
  logic             evt_valid;
  logic [1:0]       evt_ch;
  logic             evt_ack;
  logic [3:0]       overrun;

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_load, cmd_periodic, evt_ack,
    input  tick, running, evt_valid, evt_ch, overrun
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_load, cmd_periodic, evt_ack,
    output tick, running, evt_valid, evt_ch, overrun
  );
endinterface

// File: rtl/timer_scheduler.sv
// Four-channel countdown timer scheduler sharing one prescaled tick.
// Expired channels raise a pending flag; a round-robin arbiter presents one
// pending channel at a time on the event port until it is acknowledged.
module timer_scheduler #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLKcount,
  input  logic             CLR,
  timer_scheduler_if.slave bus
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    OpNop     = 2'b00,
    OpLoad    = 2'b01,
    OpStop    = 2'b10,
    OpRestart = 2'b11
  } cmdOpE;

  typedef enum logic {
    ChIdle = 1'b0,
    ChRun  = 1'b1
  } chStateE;

  // Prescaler
  logic [PreW-1:0]  preCnt;
  logic             tickInt;

  // Per-channel state
  chStateE          chState   [4];
  logic [CNT_W-1:0] remaining [4];
  logic [CNT_W-1:0] reload    [4];
  logic [3:0]       isPeriodic;
  logic [3:0]       pending;
  logic [3:0]       overrunFlags;

  // Event presentation
  logic             evtValidQ;
  logic [1:0]       evtChQ;
  logic [1:0]       rrPtr;

  // Decoded per-cycle strobes
  logic [3:0]       cmdHit;
  logic [3:0]       expire;
  logic [3:0]       ackClr;
  logic             ackFire;
  logic [1:0]       grantCh;
  logic             grantAny;

  assign tickInt = (preCnt == PreMax);

  // Prescaler: free-running 0..TICK_DIV-1, tick on the terminal count
  always_ff @(posedge CLKcount) begin
    if (CLR) begin
      preCnt <= '0;
    end else if (preCnt == PreMax) begin
      preCnt <= '0;
    end else begin
      preCnt <= preCnt + PreW'(1);
    end
  end

  // Decode which channel a command targets, which channels expire and which is acked
  always_comb begin
    cmdHit  = '0;
    expire  = '0;
    ackClr  = '0;
    ackFire = evtValidQ && bus.evt_ack;
    for (int c = 0; c < 4; c++) begin
      cmdHit[c] = bus.cmd_valid && (cmdOpE'(bus.cmd_op) != OpNop) && (bus.cmd_ch == 2'(c));
      // A command on the same channel shadows that channel's tick
      expire[c] = tickInt && !cmdHit[c] && (chState[c] == ChRun) &&
                  (remaining[c] == CNT_W'(1));
      ackClr[c] = ackFire && (evtChQ == 2'(c));
    end
  end

  // Channel state machines: commands first, then tick countdown and expiry
  always_ff @(posedge CLKcount) begin
    if (CLR) begin
      for (int c = 0; c < 4; c++) begin
        chState[c]   <= ChIdle;
        remaining[c] <= '0;
        reload[c]    <= '0;
      end
      isPeriodic   <= '0;
      pending      <= '0;
      overrunFlags <= '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (cmdHit[c]) begin
          case (cmdOpE'(bus.cmd_op))
            OpLoad: begin
              reload[c]       <= bus.cmd_load;
              remaining[c]    <= bus.cmd_load;
              isPeriodic[c]   <= bus.cmd_periodic;
              chState[c]      <= (bus.cmd_load != '0) ? ChRun : ChIdle;
              overrunFlags[c] <= 1'b0;
            end
            OpStop: begin
              chState[c]   <= ChIdle;
              remaining[c] <= '0;
            end
            OpRestart: begin
              remaining[c]    <= reload[c];
              chState[c]      <= (reload[c] != '0) ? ChRun : ChIdle;
              overrunFlags[c] <= 1'b0;
            end
            default: ;
          endcase
        end else if (tickInt && (chState[c] == ChRun)) begin
          if (expire[c]) begin
            if (isPeriodic[c]) begin
              remaining[c] <= reload[c];
            end else begin
              remaining[c] <= '0;
              chState[c]   <= ChIdle;
            end
            // An ack of this very channel in the same cycle makes room for the new event
            if (pending[c] && !ackClr[c]) begin
              overrunFlags[c] <= 1'b1;
            end
          end else begin
            remaining[c] <= remaining[c] - CNT_W'(1);
          end
        end
        pending[c] <= (pending[c] && !ackClr[c]) || expire[c];
      end
    end
  end

  // Round-robin search over pending flags starting at rrPtr
  always_comb begin
    grantCh  = rrPtr;
    grantAny = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!grantAny && pending[rrPtr + 2'(k)]) begin
        grantCh  = rrPtr + 2'(k);
        grantAny = 1'b1;
      end
    end
  end

  // Event presenter: hold a granted channel until acked, then re-arbitrate a cycle later
  always_ff @(posedge CLKcount) begin
    if (CLR) begin
      evtValidQ <= 1'b0;
      evtChQ    <= '0;
      rrPtr     <= '0;
    end else if (evtValidQ) begin
      if (bus.evt_ack) begin
        evtValidQ <= 1'b0;
        rrPtr     <= evtChQ + 2'd1;
      end
    end else if (grantAny) begin
      evtValidQ <= 1'b1;
      evtChQ    <= grantCh;
    end
  end

  // Output mapping; running comes straight from the state registers
  always_comb begin
    bus.running = '0;
    for (int c = 0; c < 4; c++) begin
      bus.running[c] = (chState[c] == ChRun);
    end
  end

  assign bus.tick      = tickInt;
  assign bus.evt_valid = evtValidQ;
  assign bus.evt_ch    = evtChQ;
  assign bus.overrun   = overrunFlags;

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50000, SHALL set the CLKcount cycles per shared tick (1 ms at 50 MHz).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the per-channel countdown.
REQ-003 CLKcount  in  1  SHALL be the single clock; all state updates on posedge.
REQ-004 CLR  in  1  SHALL be the synchronous, active-high reset.
REQ-005 cmd_valid  in  1  SHALL qualify a command for one cycle.
REQ-006 cmd_op  in  2  SHALL encode 00 nop, 01 load+start, 10 stop, 11 restart.
REQ-007 cmd_ch  in  2  SHALL select the target channel 0..3.
REQ-008 cmd_load  in  CNT_W  SHALL be the reload value in ticks (used by op 01).
REQ-009 cmd_periodic  in  1  SHALL select periodic (1) or one-shot (0) (used by op 01).
REQ-010 tick  out  1  SHALL be the shared prescaler pulse.
REQ-011 running  out  4  SHALL show per-channel RUN state.
REQ-012 evt_valid  out  1  SHALL flag a pending expiry event.
REQ-013 evt_ch  out  2  SHALL give the channel of the presented event.
REQ-014 evt_ack  in  1  SHALL consume the presented event.
REQ-015 overrun  out  4  SHALL be sticky per-channel lost-event flags.

Function
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick is high for exactly the one cycle in which count == TICK_DIV-1.
REQ-017 Each channel SHALL hold state IDLE/RUN, remaining (CNT_W), reload (CNT_W), periodic, pending.
REQ-018 Op 01 SHALL set reload = remaining = cmd_load, store periodic, enter RUN, clear overrun[ch]; with cmd_load == 0 the channel SHALL enter IDLE, remaining = 0.
REQ-019 Op 10 SHALL enter IDLE, remaining = 0; pending and overrun unchanged.
REQ-020 Op 11 SHALL set remaining = reload and enter RUN if reload != 0 (else IDLE), clearing overrun[ch].
REQ-021 On tick in RUN: remaining > 1 -> decrement; remaining == 1 -> expiry.
REQ-022 Expiry SHALL set pending[ch]; periodic -> remaining = reload, stay RUN; one-shot -> remaining = 0, IDLE.
REQ-023 Expiry while pending[ch] already set (and not acked that cycle) SHALL set overrun[ch].
REQ-024 Command and tick in the same cycle on the same channel: command wins, that tick is ignored for that channel; other channels tick normally.
REQ-025 Commands with cmd_valid low or op 00 SHALL have no effect.
REQ-026 running, evt_valid, evt_ch SHALL be registered; pending visible one cycle after the expiry tick, evt_valid one cycle after that.
REQ-027 Arbiter SHALL pick the pending channel round-robin, searching from (last granted + 1) mod 4; pointer 0 after reset.
REQ-028 While evt_valid is high, evt_ch SHALL stay stable until evt_ack.
REQ-029 On evt_valid && evt_ack: clear pending[evt_ch], pointer = evt_ch + 1, evt_valid low next cycle, re-arbitrate the cycle after.
REQ-030 Expiry on the channel being acked in the same cycle SHALL leave pending set with no overrun.
REQ-031 evt_ack while evt_valid is low SHALL be ignored.

Reset
REQ-032 CLR SHALL zero prescaler, all channel state, pending, overrun and pointer; tick, running, evt_valid, evt_ch, overrun read 0 the cycle after CLR.
REQ-033 CLR SHALL take priority over commands, ticks and ack in the same cycle; the first tick after release SHALL occur TICK_DIV cycles later.

Verification (TICK_DIV = 4)
REQ-034 Op 01 ch0 load 3 one-shot -> evt_valid with evt_ch = 0 two cycles after the 3rd tick; running[0] = 0; ack clears it.
REQ-035 Op 01 ch1 load 2 periodic, no ack -> first expiry gives evt_ch = 1; second expiry sets overrun[1]; running[1] stays 1.
REQ-036 ch0 and ch2 load 1 on the same tick -> evt_ch = 0, then after ack evt_ch = 2; next simultaneous pair starts from ch3 search (ch0 first).
REQ-037 Op 10 on ch3 with remaining = 1 one cycle before tick -> no event; running[3] = 0.
REQ-038 Op 01 ch0 load 5 in the cycle tick is high -> remaining = 5 (tick ignored); expiry after 5 further ticks.
REQ-039 CLR asserted with evt_valid high and channels running -> all outputs 0 the next cycle; tick 4 cycles after release.
